// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared encodings for the pipeline hazard controller:
//                EXE operand forwarding selects, controller states and a
//                helper that sizes the flush/hold down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  // EXE operand source selects
  localparam logic [1:0] FWD_RF       = 2'd0;
  localparam logic [1:0] FWD_MEM_ALU  = 2'd1;
  localparam logic [1:0] FWD_MEM_LOAD = 2'd2;
  localparam logic [1:0] FWD_WB       = 2'd3;

  // Controller states
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_BR_FLUSH = 2'd1,
    HZ_MDU_WAIT = 2'd2
  } hz_state_e;

  // Width of a down-counter that must hold values up to max(a, b) - 1
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_fwd_sel
//  Description : Source select for one operand: compares an operand address
//                against the MEM and WB write tags. MEM wins over WB, a MEM
//                load is reported separately from a MEM ALU result, and
//                register 0 never matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_fwd_sel
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic              mem_wb_wen_i,
  input  logic              mem_mem_ren_i,
  input  logic [REG_AW-1:0] mem_wb_addr_i,
  input  logic              wb_wb_wen_i,
  input  logic [REG_AW-1:0] wb_wb_addr_i,
  output logic [1:0]        sel_o
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_wb_wen_i && (mem_wb_addr_i != '0) && (mem_wb_addr_i == src_addr_i);
  assign w_wb_hit  = wb_wb_wen_i  && (wb_wb_addr_i  != '0) && (wb_wb_addr_i  == src_addr_i);

  // Priority select: youngest producer (MEM) first, then WB, else register file
  always_comb begin
    sel_o = FWD_RF;
    if (w_mem_hit) begin
      sel_o = mem_mem_ren_i ? FWD_MEM_LOAD : FWD_MEM_ALU;
    end else if (w_wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard, forwarding and stall controller for the 5-stage
//                pipeline. Produces EXE forwarding selects, load-use stalls,
//                a multi-cycle branch flush window and an MDU hold window,
//                plus a saturating lost-cycle counter.
//  Config      : HAZARD_FWD_EN - when defined, EXE operands are forwarded
//                from MEM/WB and only load-use stalls. When undefined the
//                selects are tied to the register file and ID stalls on any
//                source match with a writing EXE, MEM or WB instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int BRANCH_PENALTY = 3,
  parameter int MDU_LATENCY    = 4,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_branch,
  input  logic              id_is_mdu,
  input  logic [REG_AW-1:0] exe_rs_addr,
  input  logic [REG_AW-1:0] exe_rt_addr,
  input  logic              exe_wb_wen,
  input  logic              exe_mem_ren,
  input  logic [REG_AW-1:0] exe_wb_addr,
  input  logic              mem_wb_wen,
  input  logic              mem_mem_ren,
  input  logic [REG_AW-1:0] mem_wb_addr,
  input  logic              wb_wb_wen,
  input  logic [REG_AW-1:0] wb_wb_addr,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              id_flush,
  output logic              exe_flush,
  output logic              mem_flush,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int CNT_BITS = int'(cnt_width(BRANCH_PENALTY, MDU_LATENCY));

  hz_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_q;

  logic       w_rs_chk;
  logic       w_rt_chk;
  logic       w_exe_hit;
  logic       w_data_hz;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // A source only counts when the instruction is real, reads it, and it is not $0
  assign w_rs_chk  = id_valid && id_rs_used && (id_rs_addr != '0);
  assign w_rt_chk  = id_valid && id_rt_used && (id_rt_addr != '0);
  assign w_exe_hit = exe_wb_wen && ((w_rs_chk && (id_rs_addr == exe_wb_addr)) ||
                                    (w_rt_chk && (id_rt_addr == exe_wb_addr)));

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load still in EXE
  pipeline_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src_addr_i    (exe_rs_addr),
    .mem_wb_wen_i  (mem_wb_wen),
    .mem_mem_ren_i (mem_mem_ren),
    .mem_wb_addr_i (mem_wb_addr),
    .wb_wb_wen_i   (wb_wb_wen),
    .wb_wb_addr_i  (wb_wb_addr),
    .sel_o         (w_fwd_a)
  );

  pipeline_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src_addr_i    (exe_rt_addr),
    .mem_wb_wen_i  (mem_wb_wen),
    .mem_mem_ren_i (mem_mem_ren),
    .mem_wb_addr_i (mem_wb_addr),
    .wb_wb_wen_i   (wb_wb_wen),
    .wb_wb_addr_i  (wb_wb_addr),
    .sel_o         (w_fwd_b)
  );

  assign w_data_hz = w_exe_hit && exe_mem_ren;
`else
  logic [1:0] w_id_rs_sel;
  logic [1:0] w_id_rt_sel;
  logic       w_unused_exe_ops;

  // Without forwarding the same tag match detects ID sources still in flight
  pipeline_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_id_rs (
    .src_addr_i    (id_rs_addr),
    .mem_wb_wen_i  (mem_wb_wen),
    .mem_mem_ren_i (mem_mem_ren),
    .mem_wb_addr_i (mem_wb_addr),
    .wb_wb_wen_i   (wb_wb_wen),
    .wb_wb_addr_i  (wb_wb_addr),
    .sel_o         (w_id_rs_sel)
  );

  pipeline_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_id_rt (
    .src_addr_i    (id_rt_addr),
    .mem_wb_wen_i  (mem_wb_wen),
    .mem_mem_ren_i (mem_mem_ren),
    .mem_wb_addr_i (mem_wb_addr),
    .wb_wb_wen_i   (wb_wb_wen),
    .wb_wb_addr_i  (wb_wb_addr),
    .sel_o         (w_id_rt_sel)
  );

  assign w_fwd_a          = FWD_RF;
  assign w_fwd_b          = FWD_RF;
  assign w_unused_exe_ops = ^{exe_rs_addr, exe_rt_addr, exe_mem_ren};
  assign w_data_hz        = w_exe_hit ||
                            (w_rs_chk && (w_id_rs_sel != FWD_RF)) ||
                            (w_rt_chk && (w_id_rt_sel != FWD_RF));
`endif

  // State, window counter and lost-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((!if_en || id_flush) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // Next state and stage controls; reset overrides everything combinationally
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fwd_a_sel = w_fwd_a;
    fwd_b_sel = w_fwd_b;
    if_en     = 1'b1;
    id_en     = 1'b1;
    exe_en    = 1'b1;
    id_flush  = 1'b0;
    exe_flush = 1'b0;
    mem_flush = 1'b0;
    case (state_q)
      HZ_MDU_WAIT: begin
        if_en     = 1'b0;
        id_en     = 1'b0;
        exe_en    = 1'b0;
        mem_flush = 1'b1;
        cnt_d     = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) state_d = HZ_RUN;
      end
      HZ_BR_FLUSH: begin
        id_flush = 1'b1;
        cnt_d    = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) state_d = HZ_RUN;
      end
      default: begin
        if (w_data_hz) begin
          if_en     = 1'b0;
          id_en     = 1'b0;
          exe_flush = 1'b1;
        end else if (id_valid && id_is_branch) begin
          id_flush = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_d = HZ_BR_FLUSH;
            cnt_d   = CNT_BITS'(BRANCH_PENALTY - 1);
          end
        end else if (id_valid && id_is_mdu) begin
          if (MDU_LATENCY > 1) begin
            state_d = HZ_MDU_WAIT;
            cnt_d   = CNT_BITS'(MDU_LATENCY - 1);
          end
        end
      end
    endcase
    if (!rst) begin
      fwd_a_sel = FWD_RF;
      fwd_b_sel = FWD_RF;
      if_en     = 1'b0;
      id_en     = 1'b0;
      exe_en    = 1'b0;
      id_flush  = 1'b1;
      exe_flush = 1'b1;
      mem_flush = 1'b1;
    end
  end

  assign stall_cycles = stall_q;

endmodule
`default_nettype wire
